hv_job_seq: RTL
===============

HV_JOB_SEQ -- requirements
Module: hv_job_seq

Interface
REQ-001 The block SHALL use these parameters (name, default, meaning): ADDR_W, 20, n-gram/iteration address width; ITEM_W, 16, item-memory entry count width; JOB_W, 16, job count width.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset, with these ports (name, direction, width, meaning):
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_v  in  1  start request; configuration fields valid.
- cfg_ready  out  1  ready for a new start; high only in IDLE.
- cfg_ngram  in  ADDR_W  n-gram size minus one.
- cfg_iter  in  ADDR_W  iterations per job minus one.
- cfg_items  in  ITEM_W  number of item-memory entries to write.
- cfg_jobs  in  JOB_W  number of output frames to run.
- abort  in  1  return to IDLE.
- frame_done  in  1  one-cycle pulse per completed output frame (TVALID & TREADY & TLAST).
- matw  out  1  item-memory write phase.
- mat_a  out  ITEM_W  item-memory write address.
- run  out  1  data-run phase.
- last  out  1  the current job is the final one.
- addr_j  out  ADDR_W  latched cfg_ngram.
- addr_i  out  ADDR_W  latched cfg_iter.
- busy  out  1  high when the state is not IDLE.
- done  out  1  one-cycle completion pulse.
- jobs_done  out  JOB_W  frames completed since the last accepted start.

Function
REQ-003 The block SHALL implement the states IDLE, MATW, GAP, RUN and DONE.
REQ-004 In IDLE, when cfg_v is high, the block SHALL latch all cfg_* fields, clear jobs_done, and move to MATW on the next cycle; if cfg_items is 0, it SHALL move to GAP instead.
REQ-005 In MATW, matw SHALL be 1 and mat_a SHALL start at 0 and increment by 1 each cycle.
REQ-006 MATW SHALL last exactly cfg_items cycles, covering addresses 0..cfg_items-1; in the cycle where mat_a equals cfg_items-1, the next state SHALL be GAP.
REQ-007 GAP SHALL last exactly one cycle with matw=0 and run=0, then move to RUN; if cfg_jobs is 0, it SHALL move to DONE instead.
REQ-008 In RUN, run SHALL be 1, and last SHALL be 1 exactly while the remaining job count equals 1, including from the first RUN cycle when cfg_jobs is 1.
REQ-009 In RUN, each frame_done pulse SHALL increment jobs_done and decrement the remaining count; when the remaining count goes from 1 to 0, the next state SHALL be DONE and run and last SHALL both be 0 in that next cycle.
REQ-010 frame_done SHALL be ignored in every state except RUN.
REQ-011 DONE SHALL last one cycle with done=1, then move to IDLE; jobs_done SHALL keep its value until the next accepted start.
REQ-012 abort SHALL take precedence over all other events: the next cycle SHALL be IDLE with matw, run, last and done at 0, and jobs_done held.
REQ-013 When cfg_v and abort are high in the same IDLE cycle, abort SHALL win and the start SHALL be dropped.
REQ-014 addr_i and addr_j SHALL stay stable from acceptance of a start until the next accepted start.
REQ-015 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-016 mat_a SHALL NOT wrap; its maximum value is 2^ITEM_W-2.

Reset
REQ-017 While rst is high, the block SHALL hold: state=IDLE; matw, run, last and done at 0; mat_a, addr_i, addr_j and jobs_done at 0; cfg_ready=1 from the first cycle after reset releases.
REQ-018 Reset asserted mid-MATW or mid-RUN SHALL take effect on the next edge, with no completion pulse.

Structure
REQ-019 The state encoding and the ADDR_W/ITEM_W/JOB_W defaults SHALL live in the shared package, so that top and the AXI-Lite register map use the same values.
REQ-020 The block SHALL be a single module with no sub-module; the item and job counters SHALL be local down-counters.

Verification
REQ-021 The bench SHALL cover these scenarios:
- Start with items=100, jobs=3, ngram=2, iter=7 -> matw high exactly 100 cycles with mat_a 0..99; one GAP cycle; run high; last rises after the 2nd frame_done; done pulses once; jobs_done=3.
- items=0, jobs=1 -> IDLE, GAP, RUN with last=1 immediately; one frame_done -> DONE.
- jobs=0, items=4 -> 4 MATW cycles, GAP, DONE; run never rises.
- abort at MATW cycle 10 -> IDLE next cycle, matw=0, no done pulse; a new start restarts mat_a at 0.
- frame_done pulsed during MATW and IDLE -> jobs_done unchanged; rst mid-RUN -> all outputs 0 on the next cycle.
- cfg_v held high through a whole job -> the second start is accepted only in the IDLE cycle after DONE.

Source files
------------

// File: rtl/hv_job_seq_pkg.sv
// Shared definitions for the HV job sequencer: default widths and the
// state encoding, also used by the AXI-Lite register map.
package hv_job_seq_pkg;

    localparam int ADDR_W_DEF = 20;
    localparam int ITEM_W_DEF = 16;
    localparam int JOB_W_DEF  = 16;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MATW = 3'd1,
        S_GAP  = 3'd2,
        S_RUN  = 3'd3,
        S_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/hv_job_seq.sv
// Job sequencer: item-memory write phase, one gap cycle, then a run phase
// that counts completed output frames; all outputs are registered.
module hv_job_seq
    import hv_job_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int ITEM_W = ITEM_W_DEF,
    parameter int JOB_W  = JOB_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_v,
    output logic              cfg_ready,
    input  logic [ADDR_W-1:0] cfg_ngram,
    input  logic [ADDR_W-1:0] cfg_iter,
    input  logic [ITEM_W-1:0] cfg_items,
    input  logic [JOB_W-1:0]  cfg_jobs,
    input  logic              abort,
    input  logic              frame_done,
    output logic              matw,
    output logic [ITEM_W-1:0] mat_a,
    output logic              run,
    output logic              last,
    output logic [ADDR_W-1:0] addr_j,
    output logic [ADDR_W-1:0] addr_i,
    output logic              busy,
    output logic              done,
    output logic [JOB_W-1:0]  jobs_done
);

    state_t            state;
    logic [ITEM_W-1:0] item_rem;
    logic [JOB_W-1:0]  job_rem;

    // Handshake: a start is taken on any rising edge where cfg_v and
    // cfg_ready are both high and abort is low; cfg_ready is high only in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            matw      <= 1'b0;
            run       <= 1'b0;
            last      <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
            mat_a     <= '0;
            addr_i    <= '0;
            addr_j    <= '0;
            jobs_done <= '0;
            item_rem  <= '0;
            job_rem   <= '0;
        end else if (abort) begin
            // counters and jobs_done are left as-is; a new start reloads them
            state     <= S_IDLE;
            matw      <= 1'b0;
            run       <= 1'b0;
            last      <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cfg_v) begin
                        addr_j    <= cfg_ngram;
                        addr_i    <= cfg_iter;
                        item_rem  <= cfg_items;
                        job_rem   <= cfg_jobs;
                        jobs_done <= '0;
                        mat_a     <= '0;
                        busy      <= 1'b1;
                        cfg_ready <= 1'b0;
                        if (cfg_items != '0) begin
                            state <= S_MATW;
                            matw  <= 1'b1;
                        end else begin
                            state <= S_GAP;
                        end
                    end
                end
                S_MATW: begin
                    item_rem <= item_rem - 1'b1;
                    if (item_rem == ITEM_W'(1)) begin
                        state <= S_GAP;
                        matw  <= 1'b0;
                    end else begin
                        mat_a <= mat_a + 1'b1;
                    end
                end
                S_GAP: begin
                    if (job_rem == '0) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= S_RUN;
                        run   <= 1'b1;
                        last  <= (job_rem == JOB_W'(1));
                    end
                end
                S_RUN: begin
                    if (frame_done) begin
                        jobs_done <= jobs_done + 1'b1;
                        job_rem   <= job_rem - 1'b1;
                        if (job_rem == JOB_W'(1)) begin
                            state <= S_DONE;
                            run   <= 1'b0;
                            last  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            last <= (job_rem == JOB_W'(2));
                        end
                    end
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    cfg_ready <= 1'b1;
                end
                default: begin
                    state     <= S_IDLE;
                    matw      <= 1'b0;
                    run       <= 1'b0;
                    last      <= 1'b0;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    cfg_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
